// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control unit:
// opcodes, state encoding, ALU op classes, datapath mux selects and the
// packed control-word type passed from the output decoder to the top.
package multicycle_ctrl_fsm_pkg;

    // Opcodes understood by the control unit
    localparam logic [5:0] OP_RTYPE = 6'b111111;
    localparam logic [5:0] OP_ADDI  = 6'b110111;
    localparam logic [5:0] OP_LW    = 6'b100001;
    localparam logic [5:0] OP_SW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b111011;
    localparam logic [5:0] OP_BNE   = 6'b100101;
    localparam logic [5:0] OP_J     = 6'b100010;
    localparam logic [5:0] OP_JAL   = 6'b100111;

    // State encoding (4 bits; codes 11..15 are unused)
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_EXEC     = 4'd6;
    localparam logic [3:0] ST_ALU_WB   = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;
    localparam logic [3:0] ST_JUMP     = 4'd9;
    localparam logic [3:0] ST_TRAP     = 4'd10;

    // ALU op classes
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_BEQ   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_ADDI  = 3'b100;
    localparam logic [2:0] ALUOP_BNE   = 3'b110;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU operand selects
    localparam logic       SRC_A_PC      = 1'b0;
    localparam logic       SRC_A_RS      = 1'b1;
    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // Register-file destination and write-data selects
    localparam logic [1:0] REG_DST_RT   = 2'b00;
    localparam logic [1:0] REG_DST_RD   = 2'b01;
    localparam logic [1:0] REG_DST_R31  = 2'b10;
    localparam logic [1:0] M2R_ALUOUT   = 2'b00;
    localparam logic [1:0] M2R_MDR      = 2'b01;
    localparam logic [1:0] M2R_PC       = 2'b10;

    // Coarse instruction class used by the DECODE next-state choice
    typedef enum logic [2:0] {
        OPC_MEM,
        OPC_ALU,
        OPC_BRANCH,
        OPC_JUMP,
        OPC_ILLEGAL
    } op_class_e;

    // Full control word produced each cycle by the output decoder
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_type;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Map an opcode onto the instruction class that picks the post-DECODE state
    function automatic op_class_e classify_op(input logic [5:0] op);
        op_class_e cls;
        case (op)
            OP_LW, OP_SW:      cls = OPC_MEM;
            OP_RTYPE, OP_ADDI: cls = OPC_ALU;
            OP_BEQ, OP_BNE:    cls = OPC_BRANCH;
            OP_J, OP_JAL:      cls = OPC_JUMP;
            default:           cls = OPC_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_outdec.sv
// Combinational control-word decoder: {state, opcode, memory ack} -> all
// datapath enables and mux selects. Anything not driven in a state stays 0.
module multicycle_ctrl_fsm_outdec
    import multicycle_ctrl_fsm_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       mem_ack,
    output ctrl_t      ctrl
);

    // Per-state control word; the ack only matters in FETCH and MEM_WR
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                if (mem_ack) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                end
            end
            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = SRC_A_RS;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ack;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = SRC_A_RS;
                if (opcode == OP_ADDI) begin
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALUOP_ADDI;
                end else begin
                    ctrl.alu_src_b = SRC_B_RT;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
            end
            ST_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.reg_dst    = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = SRC_A_RS;
                ctrl.alu_src_b     = SRC_B_RT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_SRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                if (opcode == OP_BNE) begin
                    ctrl.alu_op      = ALUOP_BNE;
                    ctrl.branch_type = 1'b1;
                end else begin
                    ctrl.alu_op      = ALUOP_BEQ;
                    ctrl.branch_type = 1'b0;
                end
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
                // PC already holds PC+4 from FETCH, so it is the link value
                if (opcode == OP_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REG_DST_R31;
                    ctrl.mem_to_reg = M2R_PC;
                end
            end
            ST_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control unit for the MIPS-subset CPU. Holds the state
// register, next-state logic and retired-instruction counter; the control
// word itself comes from multicycle_ctrl_fsm_outdec.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ack_i,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               iord_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic               branch_type_o,
    output logic [1:0]         pc_src_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               instr_done_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   retired_cnt_o
);

    logic [3:0]       state_reg;
    logic [3:0]       state_next;
    logic [CNT_W-1:0] retired_cnt_reg;
    logic [5:0]       opcode;
    logic             ack_eff;
    ctrl_t            ctrl;

    assign opcode = 6'(instr_op_i);

    // An ack arriving together with reset must not complete anything
    assign ack_eff = mem_ack_i & ~rst_i;

    multicycle_ctrl_fsm_outdec u_outdec (
        .state   (state_reg),
        .opcode  (opcode),
        .mem_ack (ack_eff),
        .ctrl    (ctrl)
    );

    // Next-state selection; memory states hold until the ack
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: begin
                if (mem_ack_i) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (classify_op(opcode))
                    OPC_MEM:    state_next = ST_MEM_ADDR;
                    OPC_ALU:    state_next = ST_EXEC;
                    OPC_BRANCH: state_next = ST_BRANCH;
                    OPC_JUMP:   state_next = ST_JUMP;
                    default:    state_next = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LW)      state_next = ST_MEM_RD;
                else if (opcode == OP_SW) state_next = ST_MEM_WR;
                else                      state_next = ST_TRAP;
            end
            ST_MEM_RD: begin
                if (mem_ack_i) state_next = ST_MEM_WB;
            end
            ST_MEM_WR: begin
                if (mem_ack_i) state_next = ST_FETCH;
            end
            ST_EXEC:   state_next = ST_ALU_WB;
            ST_MEM_WB,
            ST_ALU_WB,
            ST_BRANCH,
            ST_JUMP:   state_next = ST_FETCH;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_FETCH;
        endcase
    end

    // State register; reset always returns to FETCH
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Retire counter: one step per done cycle, wrapping naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_cnt_reg <= '0;
        end else if (ctrl.instr_done) begin
            retired_cnt_reg <= retired_cnt_reg + 1'b1;
        end
    end

    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign iord_o          = ctrl.iord;
    assign ir_write_o      = ctrl.ir_write;
    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign branch_type_o   = ctrl.branch_type;
    assign pc_src_o        = ctrl.pc_src;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ALUOP_W'(ctrl.alu_op);
    assign reg_write_o     = ctrl.reg_write;
    assign reg_dst_o       = ctrl.reg_dst;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign instr_done_o    = ctrl.instr_done;
    assign illegal_o       = ctrl.illegal;
    assign retired_cnt_o   = retired_cnt_reg;

endmodule
